conv_out_streamer: RTL
======================

Name: conv_out_streamer

Overview:
- Read-side counterpart of the convolution layer's flat output bus.
- Captures a completed flat feature-map vector (K maps of OH x OW FP32 words) on a start pulse.
- Serialises the vector into a one-word-per-beat valid/ready stream for downstream pooling, writeback or debug capture.
- Tags every beat with its kernel index, an end-of-map flag and an end-of-frame flag.

Parameters:
- DATA_WIDTH, 32, bits per word (FP32, passed through untouched)
- K, 16, number of output kernels (feature maps)
- OH, 10, output map height
- OW, 10, output map width
- Derived: N = K*OH*OW words per frame; KW = max(1,$clog2(K))

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to capture conv_in and begin streaming
- conv_in  input  N*DATA_WIDTH  flat conv output; word 0 sits in the most significant DATA_WIDTH bits
- busy  output  1  high from the capture cycle until the done cycle inclusive
- out_data  output  DATA_WIDTH  current word
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready
- out_kidx  output  KW  kernel index of the current word
- out_last_map  output  1  current word is the last of its map (row OH-1, col OW-1)
- out_last  output  1  current word is word N-1
- done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (synchronous, dominant, any state): state=IDLE; busy, out_valid, out_last, out_last_map and done = 0; out_data = 0; out_kidx = 0; counters = 0. Reset mid-stream abandons the frame; no done pulse is issued.
- States: IDLE, STREAM, DONE.
- IDLE:
  - On start=1: latch conv_in into a shift register, clear col/row/kidx counters, go to STREAM.
  - Next cycle: out_valid=1 with word 0. Start-to-first-valid latency is 1 cycle.
- STREAM:
  - out_data = top DATA_WIDTH bits of the shift register.
  - On a handshake: shift left by DATA_WIDTH; advance col; on col wrap (OW-1 to 0) advance row; on row wrap (OH-1 to 0) advance kidx.
  - Ordering: kernel-major, then row, then column.
  - Throughput: one word per cycle while out_ready=1.
  - AXI-stream rule: while out_valid && !out_ready, out_data, out_kidx, out_last_map and out_last hold stable and out_valid stays high.
  - out_valid never drops before the handshake on word N-1.
- Flags are combinational from the counters:
  - out_last_map = (row==OH-1 && col==OW-1)
  - out_last = out_last_map && (kidx==K-1)
- Final beat: on the handshake with out_last=1, go to DONE. out_valid=0 in the next cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start is ignored in STREAM and DONE; no queueing. start is accepted again only from IDLE, so back-to-back frames have a minimum 1-cycle gap after done.
- conv_in is sampled only in the capture cycle. Later changes do not affect the frame in flight.
- Degenerate sizes: with OH=OW=1, every beat has out_last_map=1. With K=1, out_kidx is constant 0.
- No arithmetic on data; words pass bit-exact.

Decomposition:
- Shared package (conv_pkg): DATA_WIDTH default, the state enum (IDLE/STREAM/DONE), and a function computing the flat-bus width from K, OH, OW.
- One natural sub-module: conv_map_counter. It holds the nested col/row/kidx counters with an enable, and exposes wrap flags and the last_map/last decode.
- The shift register and FSM stay in the top.

Test Plan:
1. Small config K=2, OH=2, OW=2 (N=8); conv_in words 0..7 = 32'h3F800000 + i; start with out_ready held 1 -> valid at cycle+1. 8 consecutive beats in order 0..7; kidx 0,0,0,0,1,1,1,1; out_last_map on beats 3 and 7; out_last on beat 7; done 1 cycle after beat 7; busy low the cycle after.
2. Backpressure: same frame, out_ready toggling 1,0,0,1,... -> each word held stable while stalled; no drops or duplicates; scoreboard matches 0..7.
3. start pulsed again mid-stream with a different conv_in -> ignored; the original frame completes unchanged; a new start after done streams the new data.
4. reset asserted during beat 4 -> next cycle out_valid=0, busy=0, no done pulse; a fresh start streams from word 0.
5. conv_in changed every cycle after capture -> the streamed words equal the captured values only.
6. Default config (K=16, 10x10): random data, random out_ready -> 1600 beats; out_last_map every 100th beat; kidx increments 0..15; exactly one done pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output streamer.
// Contents:
//   DATA_WIDTH_DEF - default word width (FP32)
//   state_t        - streamer FSM states
//   flat_width()   - width of the flat conv output bus for a given geometry
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int flat_width(input int k, input int oh, input int ow, input int dw);
    return k * oh * ow * dw;
  endfunction

endpackage

// File: rtl/conv_map_counter.sv
// Nested column/row/kernel position counters for the output streamer.
// Order is kernel-major, then row, then column.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   clear      - zero all counters (frame capture)
//   en         - advance one position (accepted beat)
//   kidx       - current kernel index
//   col_wrap   - column is at OW-1 (next advance wraps it)
//   row_wrap   - row is at OH-1
//   last       - position is the final word of the frame
module conv_map_counter #(
  parameter int K  = 16,
  parameter int OH = 10,
  parameter int OW = 10,
  parameter int KW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [KW-1:0] kidx,
  output logic          col_wrap,
  output logic          row_wrap,
  output logic          last
);

  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          kidx_wrap;

  assign col_wrap  = (col == CW'(OW - 1));
  assign row_wrap  = (row == RW'(OH - 1));
  assign kidx_wrap = (kidx == KW'(K - 1));
  assign last      = col_wrap && row_wrap && kidx_wrap;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      kidx <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        if (row_wrap) begin
          row  <= '0;
          kidx <= kidx_wrap ? '0 : kidx + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_out_streamer.sv
// Serialises a captured flat conv output vector (K maps of OH x OW words)
// into a one-word-per-beat valid/ready stream tagged with kernel index,
// end-of-map and end-of-frame flags.
//
// state  | meaning
// IDLE   | waiting for start; start captures conv_in
// STREAM | presenting words; advance on out_valid && out_ready
// DONE   | one-cycle done pulse after the final beat
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - capture conv_in and begin a frame (IDLE only)
//   conv_in      - flat vector, word 0 in the most significant bits
//   busy         - frame in progress (STREAM or DONE)
//   out_data     - current word
//   out_valid    - out_data is valid
//   out_ready    - downstream accepts the beat
//   out_kidx     - kernel index of the current word
//   out_last_map - current word ends its map
//   out_last     - current word ends the frame
//   done         - one-cycle pulse after the final beat is accepted
module conv_out_streamer
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int K          = 16,
  parameter  int OH         = 10,
  parameter  int OW         = 10,
  localparam int KW         = (K > 1) ? $clog2(K) : 1,
  localparam int FW         = flat_width(K, OH, OW, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FW-1:0]         conv_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [KW-1:0]         out_kidx,
  output logic                  out_last_map,
  output logic                  out_last,
  output logic                  done
);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] shift_q;
  logic          capture;
  logic          beat;
  logic          col_wrap;
  logic          row_wrap;
  logic          last;
  logic [KW-1:0] kidx;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign beat = out_valid && out_ready;

  // The head word always sits in the top bits; each accepted beat shifts
  // the next word up, so the output mux is a fixed slice.
  always_ff @(posedge clk) begin
    if (reset)        shift_q <= '0;
    else if (capture) shift_q <= conv_in;
    else if (beat)    shift_q <= shift_q << DATA_WIDTH;
  end

  conv_map_counter #(
    .K  (K),
    .OH (OH),
    .OW (OW),
    .KW (KW)
  ) u_map_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (capture),
    .en       (beat),
    .kidx     (kidx),
    .col_wrap (col_wrap),
    .row_wrap (row_wrap),
    .last     (last)
  );

  // Flags are gated with out_valid so a 1x1 map does not show last_map
  // while idle.
  assign out_data     = out_valid ? shift_q[FW-1 -: DATA_WIDTH] : '0;
  assign out_kidx     = kidx;
  assign out_last_map = out_valid && col_wrap && row_wrap;
  assign out_last     = out_valid && last;

endmodule
